// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing for the SRAM port arbiter and its lane-alignment helper.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } ctrl_state_t;

  localparam int SRAM_WORDS = 128;
  localparam int SRAM_AW    = 7;
  localparam int BYTE_AW    = SRAM_AW + 2;

endpackage

// File: rtl/sram_lane_align.sv
// Combinational byte-lane logic: lane enables, alignment check, write replication
// and read extraction with sign/zero extension.
module sram_lane_align
  import sram_ctrl_pkg::*;
(
  input  access_size_t size,
  input  logic [1:0]   offset,
  input  logic         is_unsigned,
  input  logic [31:0]  wdata,
  input  logic [31:0]  rdata,
  output logic [3:0]   byte_sel,
  output logic         misaligned,
  output logic [31:0]  wdata_rep,
  output logic [31:0]  rdata_ext
);

  logic [15:0] lane;

  always_comb begin
    byte_sel   = 4'b0000;
    misaligned = 1'b0;
    wdata_rep  = 32'h0;
    rdata_ext  = 32'h0;
    // Shift the addressed lane down to bit 0 so byte and half extraction share it
    lane       = 16'(rdata >> {offset, 3'b000});
    case (size)
      BYTE: begin
        byte_sel  = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
      end
      HALF: begin
        misaligned = offset[0];
        byte_sel   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{lane[15] & ~is_unsigned}}, lane[15:0]};
      end
      WORD: begin
        misaligned = (offset != 2'b00);
        byte_sel   = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one byte-enabled SRAM between a fetch port and a
// load/store port, holding the SRAM enables for a fixed access window.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int WORDS         = SRAM_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [$clog2(WORDS)+1:0] req0_addr,
  output logic                    rsp0_valid,
  output logic [31:0]             rsp0_rdata,
  output logic                    rsp0_err,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_we,
  input  logic [1:0]              req1_size,
  input  logic                    req1_unsigned,
  input  logic [$clog2(WORDS)+1:0] req1_addr,
  input  logic [31:0]             req1_wdata,
  output logic                    rsp1_valid,
  output logic [31:0]             rsp1_rdata,
  output logic                    rsp1_err,
  output logic [$clog2(WORDS)-1:0] sram_addr_sel,
  output logic [3:0]              sram_byte_sel,
  output logic                    sram_read_enable,
  output logic                    sram_write_enable,
  output logic [31:0]             sram_datain,
  input  logic [31:0]             sram_dataout
);

  localparam int AW = $clog2(WORDS);

  ctrl_state_t  state, state_d;
  logic [3:0]   count;
  logic         last_grant, grant, accept;
  logic         port_q, we_q, uns_q, err_q;
  access_size_t size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]  wdata_q, rdata_q;

  access_size_t in_size, al_size;
  logic [AW+1:0] in_addr;
  logic         in_we, in_uns, al_uns;
  logic [31:0]  in_wdata, al_wdata;
  logic [1:0]   al_offset;
  logic [3:0]   al_byte_sel;
  logic         al_misaligned;
  logic [31:0]  al_wdata_rep, al_rdata_ext;

  // last_grant = 1 means port 1 was granted last, so port 0 wins a tie next
  always_comb begin
    grant    = req1_valid && !(req0_valid && last_grant);
    accept   = (state == IDLE) && !reset && (req0_valid || req1_valid);
    in_size  = grant ? access_size_t'(req1_size) : WORD;
    in_addr  = grant ? req1_addr : req0_addr;
    in_we    = grant & req1_we;
    in_uns   = grant & req1_unsigned;
    in_wdata = grant ? req1_wdata : 32'h0;
    // The single aligner judges the incoming request in IDLE, the latched one afterwards
    al_size   = (state == IDLE) ? in_size : size_q;
    al_offset = (state == IDLE) ? in_addr[1:0] : addr_q[1:0];
    al_uns    = (state == IDLE) ? in_uns : uns_q;
    al_wdata  = (state == IDLE) ? in_wdata : wdata_q;
  end

  sram_lane_align u_align (
    .size        (al_size),
    .offset      (al_offset),
    .is_unsigned (al_uns),
    .wdata       (al_wdata),
    .rdata       (sram_dataout),
    .byte_sel    (al_byte_sel),
    .misaligned  (al_misaligned),
    .wdata_rep   (al_wdata_rep),
    .rdata_ext   (al_rdata_ext)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = al_misaligned ? RESP : ACCESS;
      ACCESS:  if (count == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= 4'd0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= WORD;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state <= state_d;
      if (accept) begin
        last_grant <= grant;
        port_q     <= grant;
        we_q       <= in_we;
        uns_q      <= in_uns;
        size_q     <= in_size;
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
        err_q      <= al_misaligned;
        rdata_q    <= 32'h0;
        count      <= 4'(ACCESS_CYCLES - 1);
      end else if (state == ACCESS) begin
        if (count == 4'd0) begin
          if (!we_q) rdata_q <= al_rdata_ext;
        end else begin
          count <= count - 4'd1;
        end
      end
    end
  end

  always_comb begin
    req0_ready        = accept && !grant;
    req1_ready        = accept && grant;
    rsp0_valid        = (state == RESP) && !port_q;
    rsp1_valid        = (state == RESP) && port_q;
    rsp0_rdata        = rsp0_valid ? rdata_q : 32'h0;
    rsp1_rdata        = rsp1_valid ? rdata_q : 32'h0;
    rsp0_err          = rsp0_valid & err_q;
    rsp1_err          = rsp1_valid & err_q;
    sram_addr_sel     = '0;
    sram_byte_sel     = 4'b0000;
    sram_read_enable  = 1'b0;
    sram_write_enable = 1'b0;
    sram_datain       = 32'h0;
    if (state == ACCESS) begin
      sram_addr_sel     = addr_q[AW+1:2];
      sram_byte_sel     = al_byte_sel;
      sram_read_enable  = !we_q;
      sram_write_enable = we_q;
      sram_datain       = we_q ? al_wdata_rep : 32'h0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural byte-enabled SRAM model.
module tb_sram_port_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_ready;
  logic [8:0]  req0_addr = '0;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid = 1'b0, req1_ready;
  logic        req1_we = 1'b0, req1_unsigned = 1'b0;
  logic [1:0]  req1_size = 2'b10;
  logic [8:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic [6:0]  sram_addr_sel;
  logic [3:0]  sram_byte_sel;
  logic        sram_read_enable, sram_write_enable;
  logic [31:0] sram_datain, sram_dataout;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  int last_wait = 0;
  logic [3:0]  last_bsel = '0;
  logic [31:0] last_din = '0;
  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  sram_port_arbiter #(.ACCESS_CYCLES(AC), .WORDS(128)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_unsigned(req1_unsigned), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .sram_addr_sel(sram_addr_sel), .sram_byte_sel(sram_byte_sel),
    .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
    .sram_datain(sram_datain), .sram_dataout(sram_dataout)
  );

  initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (sram_write_enable)
      for (int b = 0; b < 4; b++)
        if (sram_byte_sel[b]) mem[sram_addr_sel][b*8 +: 8] <= sram_datain[b*8 +: 8];
  end

  always_comb sram_dataout = sram_read_enable ? mem[sram_addr_sel] : 32'h0;

  // Record enable activity and the lanes/data of the most recent write
  always @(negedge clk) begin
    if (sram_read_enable || sram_write_enable) en_cycles++;
    if (sram_write_enable) begin
      last_bsel = sram_byte_sel;
      last_din  = sram_datain;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_bsel;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic port, logic we, logic [1:0] size, logic uns,
                              logic [8:0] addr, logic [31:0] wdata, logic [31:0] exp_rdata,
                              logic exp_err, logic [3:0] exp_bsel, logic [31:0] exp_din);
    vec_t v;
    v.port = port; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_bsel = exp_bsel; v.exp_din = exp_din;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, wait for acceptance, then time and check its response
  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    int k;
    int en_before;
    bit got;
    logic [31:0] rd;
    logic err;
    @(negedge clk);
    if (v.port) begin
      req1_valid = 1'b1; req1_we = v.we; req1_size = v.size; req1_unsigned = v.uns;
      req1_addr = v.addr; req1_wdata = v.wdata;
    end else begin
      req0_valid = 1'b1; req0_addr = v.addr;
    end
    #1;
    cyc = 0;
    while (!(v.port ? req1_ready : req0_ready) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    last_wait = cyc;
    if (cyc >= 20) begin
      checkOutput({tag, " accept timeout"}, 32'(cyc), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    en_before = en_cycles;
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = ~req0_addr; req1_addr = ~req1_addr; req1_wdata = ~req1_wdata;
    req1_we = ~req1_we; req1_unsigned = ~req1_unsigned;
    k = 0; got = 1'b0; rd = '0; err = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      if (v.port ? rsp1_valid : rsp0_valid) begin
        got = 1'b1;
        rd  = v.port ? rsp1_rdata : rsp0_rdata;
        err = v.port ? rsp1_err : rsp0_err;
      end
    end
    checkOutput({tag, " latency"}, 32'(k), v.exp_err ? 32'd1 : 32'(AC + 1));
    checkOutput({tag, " rdata"}, rd, v.exp_rdata);
    checkOutput({tag, " err"}, 32'(err), 32'(v.exp_err));
    if (v.exp_err)
      checkOutput({tag, " sram untouched"}, 32'(en_cycles - en_before), 32'd0);
    else if (v.we) begin
      checkOutput({tag, " write byte_sel"}, 32'(last_bsel), 32'(v.exp_bsel));
      checkOutput({tag, " write datain"}, last_din, v.exp_din);
    end
    @(negedge clk);
    checkOutput({tag, " rsp idle"},
                rsp0_rdata | rsp1_rdata | {28'h0, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err},
                32'h0);
  endtask

  task automatic pulseReset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int gport[$];
    int gtime[$];
    int bad;
    $display("[TB] start");

    vecs.push_back(mk(1, 1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 2'b10, 0, 9'h010, 32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b00, 0, 9'h013, 32'h00000080, 32'h0,        0, 4'h8, 32'h80808080));
    vecs.push_back(mk(1, 0, 2'b00, 0, 9'h013, 32'h0,        32'hFFFFFF80, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b00, 1, 9'h013, 32'h0,        32'h00000080, 0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 9'h010, 32'h0,        32'h80ADBEEF, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b01, 0, 9'h022, 32'h00001234, 32'h0,        0, 4'hC, 32'h12341234));
    vecs.push_back(mk(1, 0, 2'b01, 1, 9'h022, 32'h0,        32'h00001234, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b01, 0, 9'h020, 32'h00008001, 32'h0,        0, 4'h3, 32'h80018001));
    vecs.push_back(mk(1, 0, 2'b01, 0, 9'h020, 32'h0,        32'hFFFF8001, 0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 9'h020, 32'h0,        32'h12348001, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b00, 0, 9'h011, 32'h0,        32'hFFFFFFBE, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b00, 1, 9'h012, 32'h0,        32'h000000AD, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 9'h012, 32'h0,        32'hFFFF80AD, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 9'h021, 32'h0,        32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 9'h002, 32'h0,        32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 9'h010, 32'h0,        32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 9'h012, 32'h0,        32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 9'h011, 32'hCAFEF00D, 32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b11, 0, 9'h010, 32'hFFFFFFFF, 32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 9'h010, 32'h0,        32'h80ADBEEF, 0, 4'h0, 32'h0));

    repeat (3) @(negedge clk);
    checkOutput("reset outputs",
                {7'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                 sram_read_enable, sram_write_enable, sram_byte_sel, sram_addr_sel, 4'h0},
                32'h0);
    checkOutput("reset data", rsp0_rdata | rsp1_rdata | sram_datain, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Both ports held valid from reset: expect alternating grants four cycles apart
    pulseReset(2);
    req0_addr = 9'h010;
    req1_we = 1'b0; req1_size = 2'b10; req1_unsigned = 1'b0; req1_addr = 9'h010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      if (req0_ready && req1_ready) bad++;
      if (req0_ready) begin gport.push_back(0); gtime.push_back(i); end
      if (req1_ready) begin gport.push_back(1); gtime.push_back(i); end
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("arb dual ready", 32'(bad), 32'd0);
    checkOutput("arb grant count", 32'(gport.size() >= 4), 32'd1);
    if (gport.size() >= 4) begin
      checkOutput("arb first time", 32'(gtime[0]), 32'd0);
      for (int g = 0; g < 4; g++)
        checkOutput($sformatf("arb grant%0d port", g), 32'(gport[g]), 32'(g % 2));
      for (int g = 1; g < 4; g++)
        checkOutput($sformatf("arb grant%0d spacing", g), 32'(gtime[g] - gtime[g-1]), 32'(AC + 2));
    end
    repeat (6) @(negedge clk);

    // Reset during the second write cycle abandons the store without a response
    pulseReset(2);
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b1; req1_size = 2'b10; req1_unsigned = 1'b0;
    req1_addr = 9'h040; req1_wdata = 32'h11111111;
    #1;
    checkOutput("abort accept", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort in access", 32'(sram_write_enable), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort sram idle",
                {sram_addr_sel, sram_byte_sel, sram_read_enable, sram_write_enable, 19'h0} | sram_datain,
                32'h0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp1_valid || rsp0_valid) bad++;
      @(negedge clk);
    end
    checkOutput("abort no response", 32'(bad), 32'd0);
    applyStimulus(mk(1, 0, 2'b10, 0, 9'h010, 32'h0, 32'h80ADBEEF, 0, 4'h0, 32'h0), "post-abort");
    checkOutput("post-abort immediate accept", 32'(last_wait), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Controller in front of the 128x32 byte-enabled single-port SRAM. Shares the SRAM between two requesters:
  - port 0: instruction fetch, word reads only;
  - port 1: load/store, byte/half/word, read or write.
- Arbitrates round-robin and sequences the SRAM enables for a fixed access window.
- Handles byte-lane alignment, write-lane replication, read extraction with sign/zero extension, and misalignment errors.

Parameters:
- ACCESS_CYCLES, 2, cycles the SRAM enables and address are held per access; read data is sampled on the last cycle; legal range 1..15.
- WORDS, 128, SRAM depth; sets SRAM address width (7) and byte-address width (9).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req0_valid  in  1  fetch request
- req0_ready  out  1  fetch request accepted this cycle
- req0_addr  in  9  fetch byte address
- rsp0_valid  out  1  fetch response pulse
- rsp0_rdata  out  32  fetched word
- rsp0_err  out  1  fetch misaligned
- req1_valid  in  1  load/store request
- req1_ready  out  1  load/store request accepted this cycle
- req1_we  in  1  1 = store, 0 = load
- req1_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req1_unsigned  in  1  zero-extend load result
- req1_addr  in  9  byte address
- req1_wdata  in  32  store data, right-aligned
- rsp1_valid  out  1  load/store response pulse
- rsp1_rdata  out  32  extended load data; 0 for stores
- rsp1_err  out  1  misaligned or illegal size
- sram_addr_sel  out  7  word address
- sram_byte_sel  out  4  lane enables
- sram_read_enable  out  1  SRAM read enable
- sram_write_enable  out  1  SRAM write enable
- sram_datain  out  32  lane-replicated write data
- sram_dataout  in  32  SRAM read data

Behaviour:
- Reset:
  - All outputs are 0 and state is IDLE.
  - last_grant resets so that port 0 wins the first contention.
  - Any in-flight access is abandoned and no response is issued.
- States and transitions:
  - IDLE → ACCESS: on accept of an aligned request.
  - IDLE → RESP: on accept of a misaligned request. The SRAM is not touched and the error is flagged.
  - ACCESS: enables held for ACCESS_CYCLES cycles (down-counter), then → RESP.
  - RESP: one cycle, then → IDLE.
- Acceptance:
  - Only in IDLE. req_ready is combinational, asserted for the winner only, and only while that port's valid is high.
  - Request fields are latched at acceptance. Requester inputs may change afterwards.
- Arbitration:
  - If only one port is valid, that port wins.
  - If both are valid, the port not granted last wins. last_grant updates on every accept.
- Latency:
  - Aligned request: accept at cycle T, rsp_valid at T+ACCESS_CYCLES+1.
  - Misaligned request: accept at T, rsp_valid at T+1.
  - Maximum throughput is one access per ACCESS_CYCLES+2 cycles.
- Responses:
  - Single-cycle pulse with no backpressure; the requester must take it.
  - rdata and err are valid only with rsp_valid and are 0 otherwise.
- SRAM drive:
  - Outside ACCESS, all sram_* outputs are 0.
  - In ACCESS, sram_addr_sel = addr[8:2] and byte_sel/datain come from the latched request. Exactly one of read_enable/write_enable is high.
  - sram_dataout is sampled on the final ACCESS cycle.
- Alignment:
  - Word: addr[1:0] must be 00.
  - Half: addr[0] must be 0.
  - Byte: always aligned.
  - Size 11: always an error.
  - Port 0 is always a word access and errors when addr[1:0] is not 00.
- Byte_sel (used for reads and writes):
  - byte: 1 << addr[1:0]
  - half: 0011 if addr[1] is 0, else 1100
  - word: 1111
- Write data:
  - byte: wdata[7:0] replicated ×4
  - half: wdata[15:0] replicated ×2
  - word: wdata as-is
- Read extraction:
  - Select the lane(s) at addr[1:0].
  - Sign-extend from bit 7 or bit 15 unless req1_unsigned is set.
  - Word reads pass through.
- Stores: rsp1_valid pulses with rdata = 0 after the write window.

Decomposition:
- Package sram_ctrl_pkg:
  - access_size_t enum (BYTE, HALF, WORD, ILLEGAL)
  - ctrl_state_t enum (IDLE, ACCESS, RESP)
  - SRAM_WORDS = 128, SRAM_AW = 7, BYTE_AW = 9
- Sub-module sram_lane_align, purely combinational. Given size, addr[1:0] and unsigned, it produces:
  - byte_sel
  - misaligned flag
  - replicated write data
  - extended read data

Test Plan:
- Store word 0xDEADBEEF at addr 0x010 via port 1, then port 0 fetch at 0x010 → rsp0_rdata = 0xDEADBEEF, rsp0_valid at accept+3 (ACCESS_CYCLES = 2).
- Store byte 0x80 at 0x013, then signed byte load at 0x013 → write byte_sel = 1000, datain = 0x80808080; load returns 0xFFFFFF80; unsigned load returns 0x00000080; word fetch at 0x010 returns 0x80ADBEEF.
- Half store 0x1234 at 0x022, then unsigned half load → byte_sel = 1100, rsp1_rdata = 0x00001234.
- Both ports valid continuously after reset → grants alternate 0,1,0,1; each req_ready pulse occurs only in IDLE, 4 cycles apart.
- Half load at 0x021, word load at 0x002, size = 11 → rsp1_err = 1, rdata = 0, rsp at accept+1; sram_read_enable and sram_write_enable never assert; memory unchanged.
- Assert reset in the second ACCESS cycle of a store → no rsp1_valid, all sram_* outputs 0 the next cycle, state IDLE; a subsequent request completes normally.
